// File: rtl/sc_pkg.sv
// Shared definitions for the split-unipolar binary-to-stochastic generator.
// Lane-source helpers cover both the bit-reversed counter and the SC_LFSR_EN LFSR.
package sc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLR    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Reverses the low w bits of v; the result sits in the low w bits.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = {<<{v}};
        return r >> (16 - w);
    endfunction

    // Fibonacci feedback taps (bit n-1 for polynomial term x^n), maximal length.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    // Two lanes per cycle, so 2^(w-1) cycles visit all 2^w comparator thresholds.
    function automatic int stream_len(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/sc_rng.sv
// Random-source pair r0/r1 feeding the lane comparators.
// Default: bit-reversed stream index; with SC_LFSR_EN: a W-bit Fibonacci LFSR.
module sc_rng
    import sc_pkg::*;
#(
    parameter int W    = 8,
    parameter int SEED = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init_i,
    input  logic         step_i,
    input  logic [W-2:0] k_i,
    output logic [W-1:0] r0_o,
    output logic [W-1:0] r1_o
);

`ifdef SC_LFSR_EN
    localparam logic [W-1:0] TAPS   = W'(lfsr_taps(W));
    localparam logic [W-1:0] SEED_V = (W'(SEED) == '0) ? W'(1) : W'(SEED);

    function automatic logic [W-1:0] adv(input logic [W-1:0] s);
        return {s[W-2:0], ^(s & TAPS)};
    endfunction

    logic [W-1:0] lfsr_q, lfsr_d;
    logic         unused_k;

    // r0/r1 are consumed on the same edge that advances the register by two.
    always_comb begin
        lfsr_d = lfsr_q;
        if (init_i)      lfsr_d = SEED_V;
        else if (step_i) lfsr_d = adv(adv(lfsr_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= SEED_V;
        else       lfsr_q <= lfsr_d;
    end

    assign r0_o     = lfsr_q;
    assign r1_o     = adv(lfsr_q);
    assign unused_k = ^k_i;
`else
    logic unused_rng;

    // {k,0} and {k,1} over the whole stream enumerate every W-bit threshold once.
    assign r0_o       = W'(bitrev(16'({k_i, 1'b0}), W));
    assign r1_o       = W'(bitrev(16'({k_i, 1'b1}), W));
    assign unused_rng = ^{clk, reset, init_i, step_i, SEED[0]};
`endif

endmodule

// File: rtl/bin2sc_split.sv
// Signed binary operand -> 2-lane split-unipolar stochastic stream with clear/enable strobes.
// Build option SC_LFSR_EN swaps the bit-reversed counter for an LFSR source.
module bin2sc_split
    import sc_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int LFSR_SEED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BITWIDTH:0] val_in,
    output logic              busy,
    output logic              done,
    output logic              clr_out,
    output logic              sc_vld,
    output logic [1:0]        sc_pos,
    output logic [1:0]        sc_neg
);

    localparam int KW = BITWIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(stream_len(BITWIDTH) - 1);

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [BITWIDTH:0]   mag_q, mag_d;
    logic                sign_q, sign_d;
    logic [BITWIDTH-1:0] r0, r1;
    logic [1:0]          bits;
    logic [1:0]          pos_d, neg_d;
    logic                busy_q, done_q, clr_q, vld_q;
    logic [1:0]          pos_q, neg_q;
    logic                rng_init, rng_step;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                // -2^BITWIDTH negates to itself, which reads as 2^BITWIDTH unsigned.
                mag_d   = val_in[BITWIDTH] ? -val_in : val_in;
                sign_d  = val_in[BITWIDTH];
                state_d = S_CLR;
            end
            S_CLR: begin
                k_d     = '0;
                state_d = abort ? S_IDLE : S_STREAM;
            end
            S_STREAM: begin
                if (abort)            state_d = S_IDLE;
                else if (k_q == K_LAST) state_d = S_DONE;
                else                  k_d = k_q + KW'(1);
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rng_init = (state_q == S_IDLE) && (state_d == S_CLR);
    assign rng_step = (state_d == S_STREAM);

    // Lanes are generated for the upcoming cycle so every output leaves a flop.
    sc_rng #(.W(BITWIDTH), .SEED(LFSR_SEED)) u_rng (
        .clk    (clk),
        .reset  (reset),
        .init_i (rng_init),
        .step_i (rng_step),
        .k_i    (k_d),
        .r0_o   (r0),
        .r1_o   (r1)
    );

    assign bits = {({1'b0, r1} < mag_q), ({1'b0, r0} < mag_q)};

    always_comb begin
        pos_d = '0;
        neg_d = '0;
        if (state_d == S_STREAM) begin
            if (sign_q) neg_d = bits;
            else        pos_d = bits;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            vld_q   <= 1'b0;
            pos_q   <= '0;
            neg_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            clr_q   <= (state_d == S_CLR);
            vld_q   <= (state_d == S_STREAM);
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign clr_out = clr_q;
    assign sc_vld  = vld_q;
    assign sc_pos  = pos_q;
    assign sc_neg  = neg_q;

endmodule

// File: doc/bin2sc_split.md
Name: bin2sc_split

Overview:
- Binary-to-stochastic generator that sits directly upstream of the stochastic-to-binary converter.
- Takes one signed binary operand and emits a split-unipolar, 2-bit-per-cycle stochastic stream (sc_pos/sc_neg) of fixed length.
- Also emits the matching counter-clear and count-enable strobes, so the downstream converter recovers the magnitude exactly.
- Controlled by an IDLE/CLR/STREAM/DONE state machine with a start/busy/done handshake.

Parameters:
- BITWIDTH, 8, magnitude bits; operand is BITWIDTH+1-bit two's complement; legal range 4..16.
- LFSR_SEED, 1, LFSR initial state; used only with SC_LFSR_EN; value 0 is replaced by 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  request conversion; sampled only in IDLE
- abort  in  1  terminate current conversion
- val_in  in  BITWIDTH+1  signed operand; latched on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on normal completion
- clr_out  out  1  one-cycle clear strobe to downstream counters
- sc_vld  out  1  stream-valid; drives downstream count enable
- sc_pos  out  2  positive stochastic lanes
- sc_neg  out  2  negative stochastic lanes

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE; every output is 0; index counter and latched operand are 0.
- Stream length: N = 2^(BITWIDTH-1) cycles.
- Magnitude: mag = |val_in| as a BITWIDTH+1-bit unsigned value. -2^BITWIDTH gives mag = 2^BITWIDTH, with no saturation. sign = val_in[BITWIDTH].
- IDLE: start=1 latches mag and sign, then moves to CLR.
- CLR: lasts 1 cycle with clr_out=1, then moves to STREAM and clears index k.
- STREAM: lasts N cycles with sc_vld=1 and k = 0..N-1; leaves for DONE after k = N-1.
- DONE: lasts 1 cycle with done=1, then returns to IDLE.
- Start at edge t gives clr_out in cycle t+1, sc_vld in cycles t+2..t+N+1, and done in cycle t+N+2. All outputs are registered.
- Lane generation, default build (bit-reversed counter):
  - r0 = bitrev_BITWIDTH({k,0}), r1 = bitrev_BITWIDTH({k,1}).
  - bit_j = (r_j < mag).
  - Across the stream, {r0,r1} cover 0..2^BITWIDTH-1 exactly once, so the total of ones is exactly mag.
- Sign routing: if sign=0, sc_pos = {bit1,bit0} and sc_neg = 0; otherwise the lanes are swapped. Outside STREAM, both sc_pos and sc_neg are 0.
- start while busy (including the DONE cycle): ignored; val_in is not re-latched.
- abort in CLR or STREAM: the next state is IDLE. sc_vld, sc_pos, sc_neg and clr_out are 0 from the next cycle; no done.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: start wins.
- abort in DONE: done still pulses.
- Reset mid-conversion: immediate IDLE and all outputs 0; no done. The next start behaves as from power-up.

Optional Feature:
- Macro: SC_LFSR_EN.
- Defined: the random source is a BITWIDTH-bit maximal-length Fibonacci LFSR, loaded with LFSR_SEED on entering CLR and stepped twice per STREAM cycle. r0 and r1 are its two successive states, and the comparator is unchanged. Counts are approximate. Exact at the boundaries: mag=0 gives no ones, mag=2^BITWIDTH gives all ones.
- Undefined: the bit-reversed counter above; no LFSR logic is synthesized and LFSR_SEED is unused.

Decomposition:
- Package sc_pkg:
  - state encoding localparams (IDLE, CLR, STREAM, DONE)
  - bitrev function
  - LFSR tap table indexed by BITWIDTH (4..16)
  - stream-length function
- One sub-module, sc_rng: produces r0/r1 from k (default) or from the LFSR (SC_LFSR_EN), with init and step inputs.
- The FSM, comparators and sign routing stay in bin2sc_split.

Test Plan:
- Hold reset high for 3 cycles, then release with no start: all outputs stay 0 and busy=0.
- BITWIDTH=8, val_in=+100, start pulse at edge t:
  - clr_out=1 in cycle t+1 only;
  - sc_vld=1 for exactly 128 cycles;
  - sum of sc_pos bits = 100 and sc_neg = 0 throughout;
  - done=1 in cycle t+130.
- val_in=-256: sc_neg=2'b11 in all 128 STREAM cycles and sc_pos=0. Then val_in=0: no ones on either lane, and done still pulses.
- val_in=-37 chained into the downstream converter with its counters cleared by clr_out and enabled by sc_vld: neg count = 37, pos count = 0.
- Start asserted mid-stream: ignored, stream length and count unchanged. Then abort at k=50: idle next cycle, sc_vld=0, no done, busy=0.
- Reset asserted at k=20: all outputs 0 immediately. A new start with +5 then yields exactly 5 ones and a normal done.
